// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external 32-bit ALU between two requesters
// Mul/div are held in EXEC for MD_CYCLES cycles; results return on a per-requester response handshake.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_dz,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_dz_q, rsp_dz_d;

  logic             grant;
  logic             hs;
  logic [3:0]       grant_op;
  logic             div_by_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_dz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_dz_q     <= rsp_dz_d;
    end
  end

  // Tie goes to whoever was not granted last; otherwise the sole valid requester.
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end
    hs          = (state_q == IDLE) && req_valid[grant];
    grant_op    = grant ? req1_op : req0_op;
    div_by_zero = (op_q == 4'b0011) && (b_q == '0);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_dz_d     = rsp_dz_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          op_d         = grant_op;
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = (grant_op[3:1] == 3'b001) ? MD_LOAD : 4'd0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = div_by_zero ? '1 : alu_out;
          rsp_zero_d  = div_by_zero ? 1'b0 : alu_zero;
          rsp_carry_d = alu_carry;
          rsp_dz_d    = div_by_zero;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    alu_sel   = 4'b0000;
    busy      = (state_q != IDLE);
    if (hs) begin
      req_ready[grant] = 1'b1;
    end
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
    if (state_q == EXEC) begin
      alu_sel = op_q;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_dz    = rsp_dz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// Carries a small combinational ALU so the arbiter has something to drive.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_carry, rsp_dz;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_carry, alu_zero;
  logic        busy;

  int vectors;
  int errors;

  alu_arbiter #(.WIDTH(32), .MD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_dz(rsp_dz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 sub, 2 mul, 3 div, F equal; carry is MSB of A-B.
  logic [31:0] diff;
  always_comb begin
    diff = alu_a - alu_b;
    case (alu_sel)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0001: alu_out = diff;
      4'b0010: alu_out = alu_a * alu_b;
      4'b0011: alu_out = (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
      4'b1111: alu_out = (alu_a == alu_b) ? 32'd1 : 32'd0;
      default: alu_out = 32'd0;
    endcase
    alu_carry = diff[31];
    alu_zero  = (alu_out == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    rst_n = 1'b0;
    #12;
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    vectors++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    vectors++; if ({rsp_zero, rsp_carry, rsp_dz} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rsp_zero, rsp_carry, rsp_dz}); end
    vectors++; if ({alu_a, alu_b, alu_sel} !== 68'd0) begin errors++; $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_sel}); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sub();
    req0_op = 4'b0001; req0_a = 32'd5; req0_b = 32'd7; req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sub_req_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL sub_busy: got %b expected 1", busy); end
    vectors++; if (alu_sel !== 4'b0001) begin errors++; $display("FAIL sub_alu_sel: got %b expected 0001", alu_sel); end
    vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sub_early_rsp: got %b expected 00", rsp_valid); end
    tick();
    vectors++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sub_rsp_valid: got %b expected 01", rsp_valid); end
    vectors++; if (rsp_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_data: got %h expected fffffffe", rsp_data); end
    vectors++; if ({rsp_carry, rsp_zero, rsp_dz} !== 3'b100) begin errors++; $display("FAIL sub_flags: got %b expected 100", {rsp_carry, rsp_zero, rsp_dz}); end
    vectors++; if (alu_sel !== 4'b0000) begin errors++; $display("FAIL sub_resp_alu_sel: got %b expected 0000", alu_sel); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL sub_idle_after: got %b expected 0", busy); end
    vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sub_rsp_drop: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ready [4];
    logic [31:0] exp_data [4];
    exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_data  = '{32'd2, 32'd1, 32'd2, 32'd1};
    apply_reset();
    req0_op = 4'b0000; req0_a = 32'd1; req0_b = 32'd1;
    req1_op = 4'b1111; req1_a = 32'd3; req1_b = 32'd3;
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (req_ready !== exp_ready[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_ready[i]); end
      tick();
      tick();
      vectors++; if (rsp_valid !== exp_ready[i]) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", i, rsp_valid, exp_ready[i]); end
      vectors++; if (rsp_data !== exp_data[i] || rsp_zero !== 1'b0) begin errors++; $display("FAIL rr_data[%0d]: got %h/z%b expected %h/z0", i, rsp_data, rsp_zero, exp_data[i]); end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    tick();
  endtask

  task automatic test_mul();
    req0_op = 4'b0010; req0_a = 32'd6; req0_b = 32'd7; req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mul_req_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (alu_sel !== 4'b0010 || rsp_valid !== 2'b00) begin errors++; $display("FAIL mul_exec[%0d]: got sel %b valid %b expected 0010/00", k, alu_sel, rsp_valid); end
      tick();
    end
    vectors++; if (alu_sel !== 4'b0000) begin errors++; $display("FAIL mul_exec_len: got %b expected 0000", alu_sel); end
    vectors++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd42) begin errors++; $display("FAIL mul_result: got %b/%0d expected 01/42", rsp_valid, rsp_data); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_div_zero();
    req1_op = 4'b0011; req1_a = 32'd9; req1_b = 32'd0; req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL dz_req_ready: got %b expected 10", req_ready); end
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    vectors++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL dz_rsp_valid: got %b expected 10", rsp_valid); end
    vectors++; if (rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_data: got %h expected ffffffff", rsp_data); end
    vectors++; if ({rsp_dz, rsp_zero, rsp_carry} !== 3'b100) begin errors++; $display("FAIL dz_flags: got %b expected 100", {rsp_dz, rsp_zero, rsp_carry}); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    req0_op = 4'b0000; req0_a = 32'd2; req0_b = 32'hFFFF_FFFE; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    vectors++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd0) begin errors++; $display("FAIL add_wrap_data: got %b/%h expected 01/0", rsp_valid, rsp_data); end
    vectors++; if ({rsp_zero, rsp_dz, rsp_carry} !== 3'b100) begin errors++; $display("FAIL add_wrap_flags: got %b expected 100", {rsp_zero, rsp_dz, rsp_carry}); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_back_to_back_stall();
    req0_op = 4'b0000; req0_a = 32'd10; req0_b = 32'd20; req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    req1_op = 4'b1111; req1_a = 32'd4; req1_b = 32'd4;
    tick();
    for (int k = 0; k < 10; k++) begin
      vectors++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd30 || req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++; $display("FAIL stall[%0d]: got v%b d%0d rr%b b%b expected v01 d30 rr00 b1", k, rsp_valid, rsp_data, req_ready, busy);
      end
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    vectors++; if (rsp_valid !== 2'b01 || busy !== 1'b1 || rsp_data !== 32'd30) begin errors++; $display("FAIL non_owner_ready: got v%b b%b d%0d expected v01 b1 d30", rsp_valid, busy, rsp_data); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    vectors++; if (req_ready !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL stall_release: got rr%b b%b expected rr10 b0", req_ready, busy); end
    tick();
    req_valid = 2'b00;
    tick();
    vectors++; if (rsp_valid !== 2'b10 || rsp_data !== 32'd1) begin errors++; $display("FAIL stall_req1_result: got %b/%0d expected 10/1", rsp_valid, rsp_data); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_exec();
    req0_op = 4'b0011; req0_a = 32'd100; req0_b = 32'd5; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    vectors++; if (busy !== 1'b1 || alu_sel !== 4'b0011) begin errors++; $display("FAIL mid_exec_pre: got b%b sel%b expected b1 sel0011", busy, alu_sel); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || alu_sel !== 4'b0000) begin errors++; $display("FAIL async_reset: got b%b v%b sel%b expected b0 v00 sel0000", busy, rsp_valid, alu_sel); end
    vectors++; if (rsp_data !== 32'd0 || alu_a !== 32'd0) begin errors++; $display("FAIL async_reset_regs: got d%h a%h expected 0/0", rsp_data, alu_a); end
    tick();
    rst_n = 1'b1;
    req1_op = 4'b0000; req1_a = 32'd1; req1_b = 32'd2;
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL post_reset_tie: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    vectors++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd20 || rsp_dz !== 1'b0) begin errors++; $display("FAIL div_result: got v%b d%0d dz%b expected v01 d20 dz0", rsp_valid, rsp_data, rsp_dz); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_sub();
    test_round_robin();
    test_mul();
    test_div_zero();
    test_back_to_back_stall();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU between two requesters (e.g. integer-pipe issue and a debug/CSR path). Each requester presents operands and a 4-bit op with a valid/ready handshake. The block grants requesters round-robin, drives the ALU from registered operands, and holds multiply/divide for a programmable number of cycles so the slow paths are multicycle. It then returns result and flags on a per-requester response handshake.

## Interface
- `WIDTH`, 32, operand/result width (ALU is fixed 32; only 32 supported)
- `MD_CYCLES`, 4, EXEC cycles for op 4'b0010 (mul) and 4'b0011 (div); legal range 1..15
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid[1:0]`  in  2  per-requester request valid
- `req_ready[1:0]`  out  2  per-requester request accept
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32 each  operands
- `req0_op`, `req1_op`  in  4 each  ALU select code
- `rsp_valid[1:0]`  out  2  per-requester response valid
- `rsp_ready[1:0]`  in  2  per-requester response accept
- `rsp_data`  out  32  result (shared bus; qualify with `rsp_valid`)
- `rsp_zero`, `rsp_carry`, `rsp_dz`  out  1 each  zero flag, carry flag (MSB of A-B), divide-by-zero
- `alu_a`, `alu_b`  out  32 each  to ALU A/B
- `alu_sel`  out  4  to ALU select
- `alu_out`  in  32; `alu_carry`, `alu_zero`  in  1 each  from ALU
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `grant` = the sole valid requester, or, when both are valid, the one not in `last_grant`.
  - `req_ready[grant]` = 1 combinationally only in IDLE and only when `req_valid[grant]` = 1. The other bit is 0.
  - On handshake, latch a/b/op into the operand regs, set `owner` = `grant`, `last_grant` = `grant`, load `cnt`, and go to EXEC.
- `cnt` load value: `MD_CYCLES-1` for op 0010/0011, else 0.
- EXEC:
  - `alu_a`/`alu_b`/`alu_sel` come from the operand regs.
  - Decrement `cnt` each cycle. In the cycle with `cnt` = 0, capture `alu_out`/`alu_carry`/`alu_zero` into the response regs and go to RESP.
- Divide-by-zero (op 0011 and B = 0): capture `rsp_data` = 32'hFFFF_FFFF, `rsp_zero` = 0, `rsp_dz` = 1, and `rsp_carry` from the ALU. The EXEC duration is unchanged. `rsp_dz` = 0 for all other ops.
- RESP:
  - `rsp_valid[owner]` = 1; the other bit is 0. Response regs hold stable.
  - On `rsp_ready[owner]`, go to IDLE. `rsp_ready` of the non-owner is ignored.
- Requests arriving while not IDLE are stalled (`req_ready` = 0). Requester operands need not be held after handshake.
- Requester contract: a requester must not drop `req_valid` before handshake.
- `alu_sel` = 4'b0000 in IDLE and RESP; `alu_a`/`alu_b` keep the operand-reg values.
- Reset (asynchronous, any state, including mid-EXEC or mid-RESP):
  - State goes to IDLE; any in-flight op is dropped with no response.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - Operand, response and `cnt` regs = 0.
  - Outputs: `req_ready` = 0 unless IDLE comb grant applies, `rsp_valid` = 0, `rsp_data` = 0, flags = 0, `alu_*` = 0, `busy` = 0.

## Timing
- Request handshake at edge N; EXEC occupies cycles N+1 .. N+L (L = 1, or `MD_CYCLES` for mul/div). `rsp_valid` is high from cycle N+L+1.
- Response handshake at edge M; the block is IDLE at M+1 and can accept a new request at edge M+1.
- Minimum request-to-request spacing is L+2 cycles with `rsp_ready` tied high.
- `req_ready` is a combinational function of state, `req_valid` and `last_grant` only, with no path from `rsp_*`.
- All other outputs are registered or decoded from registered state.

## Test plan
- Reset then req0 op 0001, A=5, B=7 -> `req_ready` = 2'b01, `rsp_valid` = 2'b01 two cycles after handshake, `rsp_data` = 32'hFFFF_FFFE, carry = 1, zero = 0.
- Both requesters valid simultaneously, repeatedly, with `rsp_ready` high -> grants alternate 0,1,0,1. req1 op 1111, A=B=3 -> `rsp_data` = 1, zero = 0.
- req0 op 0010, A=6, B=7, `MD_CYCLES` = 4 -> `alu_sel` = 0010 for exactly 4 cycles, `rsp_data` = 42 five cycles after handshake.
- req1 op 0011, A=9, B=0 -> `rsp_data` = 32'hFFFF_FFFF, `rsp_dz` = 1, zero = 0. Next op 0000, A=2, B=32'hFFFF_FFFE -> data = 0, zero = 1, dz = 0.
- Hold `rsp_ready` = 0 for 10 cycles in RESP while req1 is valid -> `rsp_*` stable, `req_ready` = 0, `busy` = 1. Assert `rsp_ready[1]` (non-owner) -> no effect.
- Assert `rst_n` = 0 mid-EXEC of a divide -> immediately `busy` = 0, `rsp_valid` = 0, `alu_sel` = 0. After release, tied requests grant requester 0 first.
